// File: rtl/vr_msg_dispatch.sv
// rtl/vr_msg_dispatch.sv - routes received VR messages to the prepare or commit engine by message type
// Keeps the first data beat un-consumed until the target engine has taken the metadata.
module vr_msg_dispatch #(
    parameter int                DATA_W       = 256,
    parameter int                PADBYTES_W   = 5,
    parameter int                META_W       = 96,
    parameter int                TYPE_W       = 8,
    parameter logic [TYPE_W-1:0] PREPARE_TYPE = 8'd1,
    parameter logic [TYPE_W-1:0] COMMIT_TYPE  = 8'd3,
    parameter int                CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  src_disp_meta_val,
    input  logic [META_W-1:0]     src_disp_meta,
    output logic                  disp_src_meta_rdy,
    input  logic                  src_disp_data_val,
    input  logic [DATA_W-1:0]     src_disp_data,
    input  logic                  src_disp_data_last,
    input  logic [PADBYTES_W-1:0] src_disp_data_padbytes,
    output logic                  disp_src_data_rdy,

    output logic                  manage_prep_msg_val,
    output logic [META_W-1:0]     manage_prep_msg,
    input  logic                  prep_manage_msg_rdy,
    output logic                  manage_prep_req_val,
    output logic [DATA_W-1:0]     manage_prep_req_data,
    output logic                  manage_prep_req_last,
    output logic [PADBYTES_W-1:0] manage_prep_req_padbytes,
    input  logic                  prep_manage_req_rdy,
    input  logic                  prep_engine_rdy,

    output logic                  manage_commit_msg_val,
    output logic [META_W-1:0]     manage_commit_msg,
    input  logic                  commit_manage_msg_rdy,
    output logic                  manage_commit_req_val,
    output logic [DATA_W-1:0]     manage_commit_req_data,
    output logic                  manage_commit_req_last,
    output logic [PADBYTES_W-1:0] manage_commit_req_padbytes,
    input  logic                  commit_manage_req_rdy,
    input  logic                  commit_engine_rdy,

    output logic [CNT_W-1:0]      prep_cnt,
    output logic [CNT_W-1:0]      commit_cnt,
    output logic [CNT_W-1:0]      drop_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PEEK     = 3'd1,
        DISPATCH = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                tgt_commit_q, tgt_commit_d;
    logic [META_W-1:0]   meta_q, meta_d;
    logic [CNT_W-1:0]    prep_cnt_q, prep_cnt_d;
    logic [CNT_W-1:0]    commit_cnt_q, commit_cnt_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic [TYPE_W-1:0]   msg_type;
    logic                eng_rdy, msg_rdy, req_rdy;
    logic                msg_val, req_val, meta_rdy, data_rdy;

    assign msg_type = src_disp_data[DATA_W-1 -: TYPE_W];
    assign eng_rdy  = tgt_commit_q ? commit_engine_rdy     : prep_engine_rdy;
    assign msg_rdy  = tgt_commit_q ? commit_manage_msg_rdy : prep_manage_msg_rdy;
    assign req_rdy  = tgt_commit_q ? commit_manage_req_rdy : prep_manage_req_rdy;

    always_comb begin
        state_d      = state_q;
        tgt_commit_d = tgt_commit_q;
        meta_d       = meta_q;
        prep_cnt_d   = prep_cnt_q;
        commit_cnt_d = commit_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        meta_rdy     = 1'b0;
        data_rdy     = 1'b0;
        msg_val      = 1'b0;
        req_val      = 1'b0;
        unique case (state_q)
            IDLE: begin
                meta_rdy = 1'b1;
                if (src_disp_meta_val) begin
                    meta_d  = src_disp_meta;
                    state_d = PEEK;
                end
            end
            PEEK: begin
                if (src_disp_data_val) begin
                    if (msg_type == PREPARE_TYPE) begin
                        tgt_commit_d = 1'b0;
                        state_d      = DISPATCH;
                    end else if (msg_type == COMMIT_TYPE) begin
                        tgt_commit_d = 1'b1;
                        state_d      = DISPATCH;
                    end else begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                        state_d    = DRAIN;
                    end
                end
            end
            DISPATCH: begin
                // Engine needs metadata and first beat presented together; beat stays held.
                if (eng_rdy) begin
                    msg_val = 1'b1;
                    req_val = src_disp_data_val;
                    if (msg_rdy) begin
                        if (tgt_commit_q) commit_cnt_d = commit_cnt_q + CNT_W'(1);
                        else              prep_cnt_d   = prep_cnt_q + CNT_W'(1);
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                req_val  = src_disp_data_val;
                data_rdy = req_rdy;
                if (src_disp_data_val && req_rdy && src_disp_data_last) state_d = IDLE;
            end
            DRAIN: begin
                data_rdy = 1'b1;
                if (src_disp_data_val && src_disp_data_last) state_d = IDLE;
            end
            default: begin
                state_d  = state_t'(3'bxxx);
                meta_rdy = 1'bx;
                data_rdy = 1'bx;
                msg_val  = 1'bx;
                req_val  = 1'bx;
            end
        endcase
        // Handshakes are held off while reset is asserted so nothing is exchanged mid-flush.
        if (rst) begin
            meta_rdy = 1'b0;
            data_rdy = 1'b0;
            msg_val  = 1'b0;
            req_val  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tgt_commit_q <= 1'b0;
            meta_q       <= '0;
            prep_cnt_q   <= '0;
            commit_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            tgt_commit_q <= tgt_commit_d;
            meta_q       <= meta_d;
            prep_cnt_q   <= prep_cnt_d;
            commit_cnt_q <= commit_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign disp_src_meta_rdy          = meta_rdy;
    assign disp_src_data_rdy          = data_rdy;

    assign manage_prep_msg_val        = msg_val & ~tgt_commit_q;
    assign manage_prep_msg            = meta_q;
    assign manage_prep_req_val        = req_val & ~tgt_commit_q;
    assign manage_prep_req_data       = src_disp_data;
    assign manage_prep_req_last       = src_disp_data_last;
    assign manage_prep_req_padbytes   = src_disp_data_padbytes;

    assign manage_commit_msg_val      = msg_val & tgt_commit_q;
    assign manage_commit_msg          = meta_q;
    assign manage_commit_req_val      = req_val & tgt_commit_q;
    assign manage_commit_req_data     = src_disp_data;
    assign manage_commit_req_last     = src_disp_data_last;
    assign manage_commit_req_padbytes = src_disp_data_padbytes;

    assign prep_cnt   = prep_cnt_q;
    assign commit_cnt = commit_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_vr_msg_dispatch.sv
// tb/tb_vr_msg_dispatch.sv - self-checking bench for vr_msg_dispatch
module tb_vr_msg_dispatch;
    localparam int DATA_W = 256;
    localparam int PB     = 5;
    localparam int META_W = 96;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              src_disp_meta_val, disp_src_meta_rdy;
    logic [META_W-1:0] src_disp_meta;
    logic              src_disp_data_val, src_disp_data_last, disp_src_data_rdy;
    logic [DATA_W-1:0] src_disp_data;
    logic [PB-1:0]     src_disp_data_padbytes;
    logic              manage_prep_msg_val, prep_manage_msg_rdy, manage_prep_req_val;
    logic [META_W-1:0] manage_prep_msg;
    logic [DATA_W-1:0] manage_prep_req_data;
    logic              manage_prep_req_last, prep_manage_req_rdy, prep_engine_rdy;
    logic [PB-1:0]     manage_prep_req_padbytes;
    logic              manage_commit_msg_val, commit_manage_msg_rdy, manage_commit_req_val;
    logic [META_W-1:0] manage_commit_msg;
    logic [DATA_W-1:0] manage_commit_req_data;
    logic              manage_commit_req_last, commit_manage_req_rdy, commit_engine_rdy;
    logic [PB-1:0]     manage_commit_req_padbytes;
    logic [CNT_W-1:0]  prep_cnt, commit_cnt, drop_cnt;

    vr_msg_dispatch dut (
        .clk(clk), .rst(rst),
        .src_disp_meta_val(src_disp_meta_val), .src_disp_meta(src_disp_meta),
        .disp_src_meta_rdy(disp_src_meta_rdy),
        .src_disp_data_val(src_disp_data_val), .src_disp_data(src_disp_data),
        .src_disp_data_last(src_disp_data_last), .src_disp_data_padbytes(src_disp_data_padbytes),
        .disp_src_data_rdy(disp_src_data_rdy),
        .manage_prep_msg_val(manage_prep_msg_val), .manage_prep_msg(manage_prep_msg),
        .prep_manage_msg_rdy(prep_manage_msg_rdy),
        .manage_prep_req_val(manage_prep_req_val), .manage_prep_req_data(manage_prep_req_data),
        .manage_prep_req_last(manage_prep_req_last), .manage_prep_req_padbytes(manage_prep_req_padbytes),
        .prep_manage_req_rdy(prep_manage_req_rdy), .prep_engine_rdy(prep_engine_rdy),
        .manage_commit_msg_val(manage_commit_msg_val), .manage_commit_msg(manage_commit_msg),
        .commit_manage_msg_rdy(commit_manage_msg_rdy),
        .manage_commit_req_val(manage_commit_req_val), .manage_commit_req_data(manage_commit_req_data),
        .manage_commit_req_last(manage_commit_req_last), .manage_commit_req_padbytes(manage_commit_req_padbytes),
        .commit_manage_req_rdy(commit_manage_req_rdy), .commit_engine_rdy(commit_engine_rdy),
        .prep_cnt(prep_cnt), .commit_cnt(commit_cnt), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic              tgt_commit;
        logic              drop;
        logic [DATA_W-1:0] data;
        logic              last;
        logic [PB-1:0]     pad;
    } beat_t;

    typedef struct {
        logic              tgt_commit;
        logic [META_W-1:0] meta;
    } meta_t;

    typedef struct {
        logic [7:0]  typ;
        int          nb;
        logic [PB-1:0] pad;
        int          rdy_mode;
        logic [31:0] e_prep;
        logic [31:0] e_commit;
        logic [31:0] e_drop;
    } vec_t;

    beat_t beat_q[$];
    meta_t meta_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    rdy_mode = 0;
    bit    tog = 1'b0;
    int    hold = 0;
    int    rise_cyc = -1;
    int    first_val_cyc = -1;
    int    viol_hold = 0;
    bit    meta_hs, data_hs;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic finish_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic monitor();
        beat_t b;
        meta_t m;
        logic  sv, ov, ol;
        logic [PB-1:0]     op;
        logic [DATA_W-1:0] od;
        meta_hs = src_disp_meta_val && disp_src_meta_rdy;
        data_hs = src_disp_data_val && disp_src_data_rdy;
        if ((manage_prep_msg_val || manage_prep_req_val) && (manage_commit_msg_val || manage_commit_req_val))
            chk("exclusive_val", {manage_prep_req_val, manage_commit_req_val}, 2'b00);
        if (manage_prep_msg_val || manage_commit_msg_val)
            chk("msg_req_together",
                {manage_prep_req_val | manage_commit_req_val, disp_src_data_rdy},
                {src_disp_data_val, 1'b0});
        if (hold > 0 && (manage_prep_msg_val || manage_prep_req_val || data_hs)) viol_hold++;
        if (manage_prep_msg_val && first_val_cyc < 0) first_val_cyc = cyc;
        if ((manage_prep_msg_val && prep_manage_msg_rdy) || (manage_commit_msg_val && commit_manage_msg_rdy)) begin
            if (meta_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL msg_unexpected: got meta %0h required none", manage_prep_msg);
            end else begin
                m = meta_q.pop_front();
                chk("msg_route", {manage_commit_msg_val, manage_prep_msg_val}, m.tgt_commit ? 2'b10 : 2'b01);
                chk("msg_meta", m.tgt_commit ? manage_commit_msg : manage_prep_msg, m.meta);
            end
        end
        if (data_hs) begin
            if (beat_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL beat_unexpected: got beat %0h required none", src_disp_data);
            end else begin
                b = beat_q.pop_front();
                if (b.drop) begin
                    chk("drop_no_val", {manage_prep_req_val, manage_commit_req_val}, 2'b00);
                end else begin
                    sv = b.tgt_commit ? manage_commit_req_val    : manage_prep_req_val;
                    ov = b.tgt_commit ? manage_prep_req_val      : manage_commit_req_val;
                    ol = b.tgt_commit ? manage_commit_req_last   : manage_prep_req_last;
                    op = b.tgt_commit ? manage_commit_req_padbytes : manage_prep_req_padbytes;
                    od = b.tgt_commit ? manage_commit_req_data   : manage_prep_req_data;
                    chk("beat_ctrl", {sv, ov, ol, op}, {1'b1, 1'b0, b.last, b.pad});
                    chk("beat_data", od, b.data);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        tog = ~tog;
        case (rdy_mode)
            1: begin
                prep_manage_req_rdy = tog; commit_manage_req_rdy = tog;
                prep_manage_msg_rdy = 1'b1; commit_manage_msg_rdy = 1'b1;
            end
            2: begin
                prep_manage_req_rdy   = 1'($urandom_range(0, 1));
                commit_manage_req_rdy = 1'($urandom_range(0, 1));
                prep_manage_msg_rdy   = 1'($urandom_range(0, 1));
                commit_manage_msg_rdy = 1'($urandom_range(0, 1));
            end
            default: begin
                prep_manage_req_rdy = 1'b1; commit_manage_req_rdy = 1'b1;
                prep_manage_msg_rdy = 1'b1; commit_manage_msg_rdy = 1'b1;
            end
        endcase
        if (hold > 0) begin
            hold--;
            if (hold == 0) begin
                prep_engine_rdy = 1'b1;
                rise_cyc = cyc;
            end
        end
    endtask

    task automatic send_msg(input logic [7:0] typ, input int nb, input logic [PB-1:0] pad,
                            input bit gaps, input int abort_after);
        beat_t bs[$];
        beat_t b;
        meta_t m;
        int    t, lim;
        bit    drop, tc;
        drop = !(typ == 8'd1 || typ == 8'd3);
        tc   = (typ == 8'd3);
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < DATA_W / 32; j++) b.data[32*j +: 32] = $urandom();
            if (i == 0) b.data[DATA_W-1 -: 8] = typ;
            b.tgt_commit = tc;
            b.drop       = drop;
            b.last       = (i == nb - 1);
            b.pad        = (i == nb - 1) ? pad : '0;
            bs.push_back(b);
            beat_q.push_back(b);
        end
        m.tgt_commit = tc;
        m.meta = {$urandom(), $urandom(), $urandom()};
        if (!drop) meta_q.push_back(m);
        src_disp_meta     = m.meta;
        src_disp_meta_val = 1'b1;
        t = 0;
        do begin step(); t++; end while (!meta_hs && t < 200);
        if (!meta_hs) finish_now("meta_accept");
        src_disp_meta_val = 1'b0;
        lim = (abort_after > 0) ? abort_after : nb;
        for (int i = 0; i < lim; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    src_disp_data_val = 1'b0;
                    step();
                end
            end
            src_disp_data          = bs[i].data;
            src_disp_data_last     = bs[i].last;
            src_disp_data_padbytes = bs[i].pad;
            src_disp_data_val      = 1'b1;
            t = 0;
            do begin step(); t++; end while (!data_hs && t < 200);
            if (!data_hs) finish_now("beat_accept");
            src_disp_data_val = 1'b0;
        end
        if (abort_after > 0) begin
            src_disp_data          = bs[lim].data;
            src_disp_data_last     = bs[lim].last;
            src_disp_data_padbytes = bs[lim].pad;
            src_disp_data_val      = 1'b1;
        end
    endtask

    task automatic chk_counts(input string tag, input logic [31:0] p, input logic [31:0] c, input logic [31:0] d);
        chk({tag, "_prep_cnt"}, prep_cnt, p);
        chk({tag, "_commit_cnt"}, commit_cnt, c);
        chk({tag, "_drop_cnt"}, drop_cnt, d);
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{8'd1,   1, 5'd0,  0, 32'd1, 32'd0, 32'd0};
        vt[1] = '{8'd3,   4, 5'd7,  1, 32'd1, 32'd1, 32'd0};
        vt[2] = '{8'hFF,  3, 5'd0,  0, 32'd1, 32'd1, 32'd1};
        vt[3] = '{8'd0,   2, 5'd3,  0, 32'd1, 32'd1, 32'd2};
        vt[4] = '{8'd2,   1, 5'd0,  1, 32'd1, 32'd1, 32'd3};
        vt[5] = '{8'd1,   3, 5'd31, 1, 32'd2, 32'd1, 32'd3};
        vt[6] = '{8'd3,   1, 5'd1,  0, 32'd2, 32'd2, 32'd3};

        src_disp_meta_val = 1'b0; src_disp_meta = '0;
        src_disp_data_val = 1'b0; src_disp_data = '0;
        src_disp_data_last = 1'b0; src_disp_data_padbytes = '0;
        prep_manage_msg_rdy = 1'b1; prep_manage_req_rdy = 1'b1; prep_engine_rdy = 1'b1;
        commit_manage_msg_rdy = 1'b1; commit_manage_req_rdy = 1'b1; commit_engine_rdy = 1'b1;
        rst = 1'b1;
        src_disp_meta_val = 1'b1;
        repeat (2) step();
        chk("reset_handshakes",
            {disp_src_meta_rdy, disp_src_data_rdy, manage_prep_msg_val, manage_prep_req_val,
             manage_commit_msg_val, manage_commit_req_val}, 6'b0);
        chk_counts("reset", 32'd0, 32'd0, 32'd0);
        src_disp_meta_val = 1'b0;
        rst = 1'b0;
        step();
        chk("idle_after_reset", {disp_src_meta_rdy, disp_src_data_rdy}, 2'b10);

        for (int i = 0; i < 7; i++) begin
            rdy_mode = vt[i].rdy_mode;
            send_msg(vt[i].typ, vt[i].nb, vt[i].pad, 1'b0, 0);
            rdy_mode = 0;
            chk_counts("vec", vt[i].e_prep, vt[i].e_commit, vt[i].e_drop);
            chk("vec_back_idle", disp_src_meta_rdy, 1'b1);
            chk("vec_queues_empty", beat_q.size() + meta_q.size(), 0);
        end

        prep_engine_rdy = 1'b0;
        hold = 10; rise_cyc = -1; first_val_cyc = -1; viol_hold = 0;
        send_msg(8'd1, 2, 5'd3, 1'b0, 0);
        chk("hold_no_activity", viol_hold, 0);
        chk("hold_dispatch_cycle", first_val_cyc, rise_cyc);
        chk_counts("hold", 32'd3, 32'd2, 32'd3);

        send_msg(8'd1, 5, 5'd2, 1'b0, 2);
        rst = 1'b1;
        step();
        chk("midreset_outputs",
            {disp_src_meta_rdy, disp_src_data_rdy, manage_prep_msg_val, manage_prep_req_val,
             manage_commit_msg_val, manage_commit_req_val}, 6'b0);
        chk_counts("midreset", 32'd0, 32'd0, 32'd0);
        rst = 1'b0;
        src_disp_data_val = 1'b0;
        beat_q.delete();
        meta_q.delete();
        step();
        chk("postreset_idle",
            {disp_src_meta_rdy, disp_src_data_rdy, manage_prep_msg_val, manage_prep_req_val}, 4'b1000);
        send_msg(8'd1, 2, 5'd4, 1'b0, 0);
        chk_counts("postreset", 32'd1, 32'd0, 32'd0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        rdy_mode = 2;
        for (int i = 0; i < 100; i++)
            send_msg((i % 2 == 0) ? 8'd1 : 8'd3, $urandom_range(1, 4), PB'($urandom_range(0, 31)), 1'b1, 0);
        rdy_mode = 0;
        step();
        chk_counts("b2b", 32'd50, 32'd50, 32'd0);
        chk("b2b_queues_empty", beat_q.size() + meta_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        finish_now("global_watchdog");
    end
endmodule

// File: doc/vr_msg_dispatch.md
Name: vr_msg_dispatch

Overview:
Receive-side dispatcher that sits directly upstream of the VR prepare engine and the commit engine. It takes one UDP-payload message from the receive path as a metadata beat plus a data stream, and classifies it by the message-type field in the first data beat. It routes metadata and data to the matching engine, or drops the message if the type is unknown. It also keeps per-type message counters for debug CSRs.

Parameters:
DATA_W, 256, data bus width in bits
PADBYTES_W, 5, width of the padbytes field (log2 of DATA_W/8)
META_W, 96, width of the UDP receive metadata (IP/port tuple and length)
TYPE_W, 8, width of the message-type field
PREPARE_TYPE, 8'd1, type code routed to the prepare engine
COMMIT_TYPE, 8'd3, type code routed to the commit engine
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
src_disp_meta_val  in  1  receive metadata valid
src_disp_meta  in  META_W  receive metadata
disp_src_meta_rdy  out  1  metadata accept
src_disp_data_val  in  1  receive data valid
src_disp_data  in  DATA_W  receive data; type field is bits [DATA_W-1 -: TYPE_W] of the first beat
src_disp_data_last  in  1  last beat of the message
src_disp_data_padbytes  in  PADBYTES_W  unused bytes in the last beat
disp_src_data_rdy  out  1  data accept
manage_prep_msg_val  out  1  metadata valid to the prepare engine
manage_prep_msg  out  META_W  metadata to the prepare engine
prep_manage_msg_rdy  in  1  prepare engine accepts metadata
manage_prep_req_val  out  1  data valid to the prepare engine
manage_prep_req_data  out  DATA_W  data to the prepare engine
manage_prep_req_last  out  1  last beat to the prepare engine
manage_prep_req_padbytes  out  PADBYTES_W  padbytes to the prepare engine
prep_manage_req_rdy  in  1  prepare-side data accept (log ingest)
prep_engine_rdy  in  1  prepare engine idle
manage_commit_msg_val, manage_commit_msg, commit_manage_msg_rdy, manage_commit_req_val, manage_commit_req_data, manage_commit_req_last, manage_commit_req_padbytes, commit_manage_req_rdy, commit_engine_rdy: same directions, widths and meanings as the prepare group, for the commit engine
prep_cnt  out  CNT_W  messages dispatched to the prepare engine
commit_cnt  out  CNT_W  messages dispatched to the commit engine
drop_cnt  out  CNT_W  messages dropped

Behaviour:
- Reset: state=IDLE. All val/rdy outputs are 0. All counters are 0.
- The reset is synchronous. An in-flight message is abandoned and never resumed. Upstream is flushed externally.
- Data and metadata outputs are combinational pass-throughs of the src buses, except manage_*_msg, which comes from the meta register.
- State IDLE:
  - disp_src_meta_rdy=1.
  - On src_disp_meta_val, latch meta into meta_reg and go to PEEK.
- State PEEK:
  - disp_src_data_rdy=0; the first beat is held and not consumed.
  - When src_disp_data_val is high, decode the type field:
    - PREPARE_TYPE: tgt=PREP, go to DISPATCH.
    - COMMIT_TYPE: tgt=COMMIT, go to DISPATCH.
    - Otherwise: drop_cnt++, go to DRAIN.
  - Type is registered, so DISPATCH begins one cycle after decode.
- State DISPATCH:
  - While the target's *_engine_rdy is 0, all outputs stay 0 (wait).
  - When *_engine_rdy is 1:
    - Assert manage_<tgt>_msg_val.
    - Assert manage_<tgt>_req_val = src_disp_data_val, on the same cycle. The engine requires both to be valid together.
    - disp_src_data_rdy stays 0.
  - On <tgt>_manage_msg_rdy: increment the target counter and go to STREAM. The first data beat is not consumed here.
- State STREAM:
  - manage_<tgt>_req_val = src_disp_data_val.
  - disp_src_data_rdy = <tgt>_manage_req_rdy.
  - last and padbytes pass through.
  - On a handshake with last=1, go to IDLE. This covers single-beat messages.
- State DRAIN:
  - disp_src_data_rdy=1. Beats are discarded.
  - On a handshake with last=1, go to IDLE.
- The non-selected engine never sees val=1.
- Counters wrap modulo 2^CNT_W with no saturation.
- Meta for message N+1 is not accepted until message N has returned to IDLE. There is no overlap.
- Back-to-back messages need at least 3 cycles overhead: IDLE, PEEK, DISPATCH.
- Illegal state: drive X on outputs and next state.

Test Plan:
- Single-beat prepare (type 1, last=1, engine rdy, rdy always 1):
  - manage_prep_msg_val and req_val are high together in DISPATCH.
  - The beat is consumed in STREAM.
  - prep_cnt=1; the commit interface stays idle; FSM is back in IDLE.
- 4-beat commit message, commit_manage_req_rdy toggling 1,0,1,0:
  - All 4 beats are delivered in order with last only on beat 4.
  - padbytes=7 is forwarded on the last beat.
  - commit_cnt=1.
- Prepare while prep_engine_rdy=0 for 10 cycles:
  - No val asserted and no src beats consumed while it is low.
  - Dispatch proceeds in the cycle after prep_engine_rdy rises.
- Unknown type 8'hFF, 3 beats:
  - disp_src_data_rdy=1 in DRAIN; all 3 beats are consumed.
  - drop_cnt=1; neither engine sees val.
- Reset asserted mid-STREAM (after beat 2 of 5):
  - Next cycle all outputs are 0, counters are 0, and state is IDLE.
  - A new prepare message then dispatches normally.
- 100 back-to-back alternating prepare/commit messages with random upstream valid gaps:
  - prep_cnt=50, commit_cnt=50, drop_cnt=0.
  - Scoreboard shows data identical and no beat duplicated or lost.
